// File: rtl/sd_data_in_dispatch.sv
// sd_data_in_dispatch
// -------------------
// Takes one 32-bit word at a time from an SRAM-side valid/ready source and
// forwards it to exactly one of three SD channels.
//
// Routing of each accepted word:
//   - selectid == sram1sd : channel 1 (this match wins when both ids match)
//   - selectid == sram2sd : channel 2
//   - otherwise           : channel 3
//
// A word is accepted in IDLE only. It is then presented in SEND until the
// selected channel handshakes. Valid and data are held while that channel's
// ready stays low; there is no timeout.
//
// Optional feature (macro PARITY_GEN_EN):
//   - RAID5-style parity. The XOR of every accepted word is accumulated.
//   - After the second data word of a stripe completes, the block enters
//     PARITY. It drives the accumulator on the lowest-indexed channel that
//     no word of the stripe used.
//   - When the macro is undefined, no accumulator, count or mask logic is
//     built and SEND always returns to IDLE.
//
// Ports:
//   clk, n_rst                  clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data   SRAM-side word handshake
//   selectid, sram1sd, sram2sd  routing ids, sampled with in_data
//   sdN_valid/sdN_ready/sdN_data  per-channel handshake (N = 1..3)
//   busy                        high whenever the state is not IDLE
module sd_data_in_dispatch (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  selectid,
  input  logic [1:0]  sram1sd,
  input  logic [1:0]  sram2sd,
  output logic [31:0] sd1_data,
  output logic [31:0] sd2_data,
  output logic [31:0] sd3_data,
  output logic        sd1_valid,
  output logic        sd2_valid,
  output logic        sd3_valid,
  input  logic        sd1_ready,
  input  logic        sd2_ready,
  input  logic        sd3_ready,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
`ifdef PARITY_GEN_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  // One-hot channel code: bit 0 = ch1, bit 1 = ch2, bit 2 = ch3.
  function automatic logic [2:0] decode_ch(input logic [1:0] sel,
                                           input logic [1:0] id1,
                                           input logic [1:0] id2);
    if (sel == id1) begin
      decode_ch = 3'b001;
    end else if (sel == id2) begin
      decode_ch = 3'b010;
    end else begin
      decode_ch = 3'b100;
    end
  endfunction

`ifdef PARITY_GEN_EN
  // Lowest-indexed channel not yet used by the stripe.
  function automatic logic [2:0] free_ch(input logic [2:0] used);
    if (!used[0]) begin
      free_ch = 3'b001;
    end else if (!used[1]) begin
      free_ch = 3'b010;
    end else begin
      free_ch = 3'b100;
    end
  endfunction

  logic [31:0] acc_q, acc_d;
  logic        cnt_q, cnt_d;
  logic [2:0]  mask_q, mask_d;
`endif

  logic [1:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  valid_q, valid_d;
  logic [31:0] data_q [3];
  logic [31:0] data_d [3];
  logic        busy_q, busy_d;
  logic [31:0] payload_s;
  logic [2:0]  sd_ready_s;
  logic        accept_s;
  logic        done_s;

  assign sd_ready_s = {sd3_ready, sd2_ready, sd1_ready};
  // Gated by n_rst so in_ready reads 0 while reset is held, and reads 1 on
  // the first edge after release.
  assign in_ready   = n_rst & (state_q == ST_IDLE);
  assign accept_s   = in_valid & in_ready;
  // Only the driven channel's ready can complete a transfer.
  assign done_s     = |(valid_q & sd_ready_s);

  // Next-state, holding register and registered channel outputs.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    word_d    = word_q;
    valid_d   = 3'b000;
    payload_s = 32'd0;
`ifdef PARITY_GEN_EN
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mask_d = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SEND;
          sel_d   = decode_ch(selectid, sram1sd, sram2sd);
          word_d  = in_data;
`ifdef PARITY_GEN_EN
          acc_d   = acc_q ^ in_data;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (done_s) begin
`ifdef PARITY_GEN_EN
          mask_d = mask_q | sel_q;
          if (cnt_q) begin
            state_d = ST_PARITY;
          end else begin
            cnt_d   = 1'b1;
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_SEND;
        end
      end
`ifdef PARITY_GEN_EN
      ST_PARITY: begin
        if (done_s) begin
          acc_d   = 32'd0;
          cnt_d   = 1'b0;
          mask_d  = 3'b000;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the next state so they are valid from the cycle after
    // acceptance and come straight out of flops.
    if (state_d == ST_SEND) begin
      valid_d   = sel_d;
      payload_s = word_d;
`ifdef PARITY_GEN_EN
    end else if (state_d == ST_PARITY) begin
      valid_d   = free_ch(mask_d);
      payload_s = acc_d;
`endif
    end else begin
      valid_d   = 3'b000;
      payload_s = 32'd0;
    end
    for (int i = 0; i < 3; i++) begin
      data_d[i] = valid_d[i] ? payload_s : 32'd0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'b000;
      word_q  <= 32'd0;
      valid_q <= 3'b000;
      busy_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= 32'd0;
      end
`ifdef PARITY_GEN_EN
      acc_q  <= 32'd0;
      cnt_q  <= 1'b0;
      mask_q <= 3'b000;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= data_d[i];
      end
`ifdef PARITY_GEN_EN
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
`endif
    end
  end

  assign sd1_valid = valid_q[0];
  assign sd2_valid = valid_q[1];
  assign sd3_valid = valid_q[2];
  assign sd1_data  = data_q[0];
  assign sd2_data  = data_q[1];
  assign sd3_data  = data_q[2];
  assign busy      = busy_q;

endmodule

// File: doc/sd_data_in_dispatch.md
SD_DATA_IN_DISPATCH -- requirements
Module: sd_data_in_dispatch

Interface
REQ-001 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  SRAM-side word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  32  SRAM-side data word.
- selectid  in  2  target id of the word, sampled with in_data.
- sram1sd  in  2  id mapped to SD channel 1, sampled with in_data.
- sram2sd  in  2  id mapped to SD channel 2, sampled with in_data.
- sd1_data / sd2_data / sd3_data  out  32 each  per-channel data.
- sd1_valid / sd2_valid / sd3_valid  out  1 each  per-channel valid.
- sd1_ready / sd2_ready / sd3_ready  in  1 each  per-channel ready.
- busy  out  1  high whenever state is not IDLE.
REQ-002 SHALL use one clock; reset is asynchronous and active-low (clk, n_rst).

Function
REQ-003 Channel decode at acceptance SHALL be:
- selectid==sram1sd -> ch1;
- else selectid==sram2sd -> ch2;
- else ch3.
- ch1 wins when both ids match.
REQ-004 States SHALL be IDLE, SEND, PARITY; PARITY exists only per REQ-016.
REQ-005 In IDLE, in_ready=1; in all other states in_ready=0.
REQ-006 An accept SHALL occur when in_valid & in_ready at a clock edge:
- latch in_data and the decoded channel;
- next state SEND.
REQ-007 In SEND, only the latched channel's sdN_valid=1, with sdN_data = latched word; the other valids SHALL be 0.
REQ-008 A transfer SHALL complete on a cycle with sdN_valid & sdN_ready.
REQ-009 While sdN_ready=0, valid and data SHALL hold stable; there is no timeout.
REQ-010 Minimum accept-to-valid latency SHALL be 1 cycle; minimum word throughput SHALL be one per 2 cycles (IDLE->SEND->IDLE).
REQ-011 A ready asserted on a non-selected channel SHALL be ignored.
REQ-012 sdN_data for non-selected channels SHALL be 0.
REQ-013 in_valid during SEND or PARITY SHALL NOT be accepted and SHALL NOT alter latched state.

Reset
REQ-014 While n_rst=0, all of the following SHALL hold:
- state=IDLE;
- every sdN_valid=0 and every sdN_data=0;
- busy=0;
- in_ready=0;
- holding register, parity accumulator, stripe count and used-mask cleared.
REQ-015 Reset asserted mid-transfer SHALL drop the in-flight word and any partial stripe with no further valid pulses; after release, the first edge sees state IDLE with in_ready=1.

Configuration
REQ-016 Macro PARITY_GEN_EN, when defined, SHALL enable RAID5 parity generation:
- acc ^= word on each accept;
- stripe count (0..1) increments on each completed SEND;
- 3-bit used-mask records the channel of each completed SEND.
REQ-017 With PARITY_GEN_EN, completing the second data word of a stripe SHALL go to PARITY instead of IDLE:
- drive acc on the parity channel = lowest-indexed channel not in used-mask;
- on ready, clear acc, count and mask, then go IDLE.
REQ-018 Without PARITY_GEN_EN:
- SEND always returns to IDLE;
- no accumulator, count or mask logic is synthesized;
- the PARITY state is unreachable and absent.

Verification
REQ-019 Bench SHALL cover the following directed scenarios:
- Routing: sram1sd=1, sram2sd=2; send selectid=1, 2, 3 with all readies high -> sd1_valid, sd2_valid, sd3_valid each pulse once, 1 cycle after accept, with the correct word.
- Backpressure: selectid=2 with sd2_ready low for 5 cycles -> sd2_valid and data held for 6 cycles, in_ready=0 throughout, second in_valid ignored until completion.
- Tie: sram1sd=sram2sd=0, selectid=0 -> ch1 only.
- Parity (macro on): words 0xA5A5_0000 to ch1 and 0x0000_5A5A to ch2 -> sd3 receives 0xA5A5_5A5A, then busy=0.
- Parity with both words to ch1 -> parity goes to ch2.
- Reset: n_rst low during SEND with ready low -> all valids drop immediately, busy=0; after release, next stripe parity reflects only new words.
